// File: rtl/spi_target_regs_pkg.sv
// Shared constants and types for the SPI target register block.
//   DEFAULT_ADDR_W : default register address width (32 registers)
//   CMD_*          : field positions inside the command byte
//   BITS_PER_BYTE  : SPI frame byte length
//   spi_state_t    : transaction FSM states
package spi_target_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int CMD_ADDR_MSB   = 7;
  localparam int CMD_ADDR_LSB   = 3;
  localparam int CMD_DIR_BIT    = 1;
  localparam int BITS_PER_BYTE  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_target_regs_if.sv
// SPI pin bundle between an initiator and the target register block.
//   sclk     : SPI clock, CPOL=0 (initiator -> target)
//   ss_n     : active-low select (initiator -> target)
//   mosi     : initiator data, MSB first
//   miso     : target data, MSB first
//   miso_oe  : MISO drive enable, the pad tri-states when low
interface spi_target_regs_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output ss_n,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  ss_n,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_target_regs_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by one history
// flop that yields single-cycle rise/fall strobes.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : asynchronous input pin
//   sync_out   : synchronized level
//   rise, fall : one-cycle strobes on synchronized transitions
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign sync_out = sync_reg[STAGES-1];
  assign rise     = sync_reg[STAGES-1] & ~prev_reg;
  assign fall     = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target exposing a register file to an external initiator.
// Frame: command byte {addr[4:0], x, dir, x} then data bytes; the status
// byte is shifted out on MISO during the command byte. All SPI pins are
// oversampled in the Clk domain.
//   Clk, Reset_n     : system clock, asynchronous active-low reset
//   spi              : SPI pins (slave modport)
//   status           : byte returned during the command byte
//   host_addr/we/wdata/rdata : fabric-side register port, 1-cycle read
//   wr_pulse/addr/data       : notification of each committed SPI write
//   busy             : high while the synchronized select is low
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  spi_target_regs_if.slave  spi,
  input  logic [7:0]        status,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic sclk_level_unused, ss_level_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(Clk), .rst_n(Reset_n), .din(spi.sclk),
    .sync_out(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(Clk), .rst_n(Reset_n), .din(spi.ss_n),
    .sync_out(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
  );

  // MOSI goes through the same depth so it stays aligned with the SCLK strobes.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(Clk), .rst_n(Reset_n), .din(spi.mosi),
    .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [7:0]        mem_reg [NUM_REGS];
  spi_state_t        state_reg, state_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        rx_reg, rx_next;
  logic [7:0]        tx_reg, tx_next;
  logic              miso_reg, miso_next;
  logic              oe_reg, oe_next;
  logic              busy_reg, busy_next;
  logic              dir_write_reg, dir_write_next;
  logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
  logic              wr_pulse_reg, wr_pulse_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic [7:0]        host_rdata_reg;
  logic              spi_we;
  logic [7:0]        byte_in;
  logic              byte_done;
  logic [ADDR_W-1:0] cmd_addr, addr_inc;

  assign byte_in   = {rx_reg[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_reg == 3'(BITS_PER_BYTE - 1));
  assign cmd_addr  = ADDR_W'(byte_in[CMD_ADDR_MSB:CMD_ADDR_LSB]);
  assign addr_inc  = addr_ptr_reg + ADDR_W'(1);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_next        = rx_reg;
    tx_next        = tx_reg;
    miso_next      = miso_reg;
    oe_next        = oe_reg;
    busy_next      = busy_reg;
    dir_write_next = dir_write_reg;
    addr_ptr_next  = addr_ptr_reg;
    wr_pulse_next  = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    spi_we         = 1'b0;

    if (ss_rise) begin
      // Deselect aborts any partial byte without side effects.
      state_next   = IDLE;
      oe_next      = 1'b0;
      busy_next    = 1'b0;
      miso_next    = 1'b0;
      bit_cnt_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (ss_fall) begin
            state_next   = CMD;
            oe_next      = 1'b1;
            busy_next    = 1'b1;
            miso_next    = status[7];
            // MSB is already on the pin, so the shifter holds the rest.
            tx_next      = {status[6:0], 1'b0};
            bit_cnt_next = '0;
          end
        end
        CMD, DATA: begin
          if (sclk_rise) begin
            rx_next      = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end else if (sclk_fall) begin
            miso_next = tx_reg[7];
            tx_next   = {tx_reg[6:0], 1'b0};
          end
          if (byte_done) begin
            if (state_reg == CMD) begin
              state_next     = DATA;
              addr_ptr_next  = cmd_addr;
              dir_write_next = byte_in[CMD_DIR_BIT];
              tx_next        = byte_in[CMD_DIR_BIT] ? 8'h00 : mem_reg[cmd_addr];
            end else if (dir_write_reg) begin
              spi_we        = 1'b1;
              wr_pulse_next = 1'b1;
              wr_addr_next  = addr_ptr_reg;
              wr_data_next  = byte_in;
              addr_ptr_next = addr_inc;
              tx_next       = 8'h00;
            end else begin
              addr_ptr_next = addr_inc;
              tx_next       = mem_reg[addr_inc];
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      miso_reg      <= 1'b0;
      oe_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      dir_write_reg <= 1'b0;
      addr_ptr_reg  <= '0;
      wr_pulse_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_reg        <= rx_next;
      tx_reg        <= tx_next;
      miso_reg      <= miso_next;
      oe_reg        <= oe_next;
      busy_reg      <= busy_next;
      dir_write_reg <= dir_write_next;
      addr_ptr_reg  <= addr_ptr_next;
      wr_pulse_reg  <= wr_pulse_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  // SPI write is issued last so it overrides a host write to the same address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= 8'h00;
      host_rdata_reg <= 8'h00;
    end else begin
      host_rdata_reg <= mem_reg[host_addr];
      if (host_we) mem_reg[host_addr] <= host_wdata;
      if (spi_we)  mem_reg[addr_ptr_reg] <= byte_in;
    end
  end

  assign spi.miso    = miso_reg;
  assign spi.miso_oe = oe_reg;
  assign host_rdata  = host_rdata_reg;
  assign wr_pulse    = wr_pulse_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_spi_target_regs.sv
module tb_spi_target_regs;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        status = 8'h00;
  logic [ADDR_W-1:0] host_addr = '0;
  logic              host_we = 1'b0;
  logic [7:0]        host_wdata = 8'h00;
  logic [7:0]        host_rdata;
  logic              wr_pulse;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboards: expected SPI write commits and expected MISO bytes.
  logic [12:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  spi_target_regs_if spi_bus();

  spi_target_regs #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .Clk(clk), .Reset_n(rst_n), .spi(spi_bus), .status(status),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #10 clk = ~clk;

  // Write-commit monitor: every wr_pulse must match the head of exp_wr.
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      logic [12:0] e;
      tests_run++;
      if (exp_wr.size() == 0) begin
        tests_failed++;
        $display("FAIL wr_commit: unexpected pulse addr=%0d data=%h, required none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          tests_failed++;
          $display("FAIL wr_commit: got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr, wr_data, e[12:8], e[7:0]);
        end else
          $display("[TB] wr_commit addr=%0d data=%h", wr_addr, wr_data);
      end
    end
  end

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  task automatic spi_begin();
    spi_bus.sclk = 1'b0;
    spi_bus.ss_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (4) @(negedge clk);
    spi_bus.ss_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Shifts nbits MSB-first; SCLK half period is 4 Clk cycles. With collide set,
  // a host write is placed exactly in the cycle the final bit commits.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit collide,
                          input logic [ADDR_W-1:0] c_addr, input logic [7:0] c_data,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_bus.mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = spi_bus.miso;
      spi_bus.sclk = 1'b1;
      if (collide && i == 0) begin
        repeat (2) @(negedge clk);
        host_addr = c_addr; host_wdata = c_data; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
        tests_run++;
        if (wr_pulse !== 1'b1) begin
          tests_failed++;
          $display("FAIL collide_align: wr_pulse=%b, required 1", wr_pulse);
        end
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tests_run++;
    if ({spi_bus.miso, spi_bus.miso_oe, host_rdata, wr_pulse, wr_addr, wr_data, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: miso=%b oe=%b rdata=%h pulse=%b waddr=%0d wdata=%h busy=%b, required all 0",
               spi_bus.miso, spi_bus.miso_oe, host_rdata, wr_pulse, wr_addr, wr_data, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      host_read(ADDR_W'(a), d);
      tests_run++;
      if (d !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_reg%0d: got %h, required 00", a, d);
      end
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_write();
    logic [7:0] rx, d;
    exp_wr.push_back({5'd3, 8'h5A});
    spi_begin();
    spi_bits(8'h1A, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'h5A, 8, 1'b0, '0, 8'h00, rx);
    spi_end();
    host_read(5'd3, d);
    tests_run++;
    if (d !== 8'h5A) begin
      tests_failed++;
      $display("FAIL write_reg3: host_rdata=%h, required 5a", d);
    end
    $display("[TB] write reg3 <= 5a, readback %h", d);
  endtask

  task automatic test_status_echo();
    logic [7:0] rx, e;
    status = 8'hC3;
    tests_run++;
    if (spi_bus.miso_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL oe_idle: oe=%b, required 0", spi_bus.miso_oe);
    end
    exp_rd.push_back(8'hC3);
    exp_rd.push_back(8'h5A);
    spi_begin();
    tests_run++;
    if (spi_bus.miso_oe !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL oe_selected: oe=%b busy=%b, required 1 1", spi_bus.miso_oe, busy);
    end
    spi_bits(8'h18, 8, 1'b0, '0, 8'h00, rx);
    e = exp_rd.pop_front();
    tests_run++;
    if (rx !== e) begin
      tests_failed++;
      $display("FAIL status_echo: miso byte=%h, required %h", rx, e);
    end
    spi_bits(8'h00, 8, 1'b0, '0, 8'h00, rx);
    e = exp_rd.pop_front();
    tests_run++;
    if (rx !== e) begin
      tests_failed++;
      $display("FAIL read_reg3: miso byte=%h, required %h", rx, e);
    end
    spi_end();
    tests_run++;
    if (spi_bus.miso_oe !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL oe_release: oe=%b busy=%b, required 0 0", spi_bus.miso_oe, busy);
    end
    $display("[TB] status echo and read reg3 done");
  endtask

  task automatic test_burst_wrap();
    logic [7:0] rx, e;
    host_write(5'd30, 8'h11);
    host_write(5'd31, 8'h22);
    host_write(5'd0, 8'h33);
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    exp_rd.push_back(8'h33);
    spi_begin();
    spi_bits(8'hF0, 8, 1'b0, '0, 8'h00, rx);
    for (int k = 0; k < 3; k++) begin
      spi_bits(8'hFF, 8, 1'b0, '0, 8'h00, rx);
      e = exp_rd.pop_front();
      tests_run++;
      if (rx !== e) begin
        tests_failed++;
        $display("FAIL burst_byte%0d: miso byte=%h, required %h", k, rx, e);
      end else
        $display("[TB] burst byte %0d = %h", k, rx);
    end
    spi_end();
  endtask

  task automatic test_abort();
    logic [7:0] rx, d;
    host_write(5'd1, 8'h3C);
    spi_begin();
    spi_bits(8'h0A, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'hF8, 5, 1'b0, '0, 8'h00, rx);
    repeat (4) @(negedge clk);
    spi_bus.ss_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: busy=%b after 3 cycles, required 0", busy);
    end
    repeat (4) @(negedge clk);
    host_read(5'd1, d);
    tests_run++;
    if (d !== 8'h3C) begin
      tests_failed++;
      $display("FAIL abort_reg1: got %h, required 3c", d);
    end
    $display("[TB] abort after 5 bits, reg1 = %h", d);
  endtask

  task automatic test_collision();
    logic [7:0] rx, d;
    exp_wr.push_back({5'd7, 8'hAA});
    spi_begin();
    spi_bits(8'h3A, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'hAA, 8, 1'b1, 5'd7, 8'h55, rx);
    spi_end();
    host_read(5'd7, d);
    tests_run++;
    if (d !== 8'hAA) begin
      tests_failed++;
      $display("FAIL collide_same: reg7=%h, required aa", d);
    end
    $display("[TB] collision same addr, reg7 = %h", d);

    host_write(5'd7, 8'h00);
    host_write(5'd8, 8'h00);
    exp_wr.push_back({5'd7, 8'hAA});
    spi_begin();
    spi_bits(8'h3A, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'hAA, 8, 1'b1, 5'd8, 8'h55, rx);
    spi_end();
    host_read(5'd7, d);
    tests_run++;
    if (d !== 8'hAA) begin
      tests_failed++;
      $display("FAIL collide_diff_reg7: got %h, required aa", d);
    end
    host_read(5'd8, d);
    tests_run++;
    if (d !== 8'h55) begin
      tests_failed++;
      $display("FAIL collide_diff_reg8: got %h, required 55", d);
    end
    $display("[TB] collision different addr, reg8 = %h", d);
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] rx, d, e;
    int bad;
    exp_wr.push_back({5'd4, 8'h77});
    spi_begin();
    spi_bits(8'h22, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'h77, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'hE1, 4, 1'b0, '0, 8'h00, rx);
    spi_bus.sclk = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({spi_bus.miso, spi_bus.miso_oe, host_rdata, wr_pulse, wr_addr, wr_data, busy} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: miso=%b oe=%b rdata=%h pulse=%b waddr=%0d wdata=%h busy=%b, required all 0",
               spi_bus.miso, spi_bus.miso_oe, host_rdata, wr_pulse, wr_addr, wr_data, busy);
    end
    @(negedge clk);
    spi_bus.sclk = 1'b0; spi_bus.ss_n = 1'b1; spi_bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      host_read(ADDR_W'(a), d);
      if (d !== 8'h00) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL midreset_regs: %0d registers nonzero, required 0", bad);
    end
    exp_wr.push_back({5'd9, 8'h99});
    spi_begin();
    spi_bits(8'h4A, 8, 1'b0, '0, 8'h00, rx);
    spi_bits(8'h99, 8, 1'b0, '0, 8'h00, rx);
    spi_end();
    exp_rd.push_back(8'hC3);
    exp_rd.push_back(8'h99);
    spi_begin();
    spi_bits(8'h48, 8, 1'b0, '0, 8'h00, rx);
    e = exp_rd.pop_front();
    tests_run++;
    if (rx !== e) begin
      tests_failed++;
      $display("FAIL post_reset_status: miso byte=%h, required %h", rx, e);
    end
    spi_bits(8'h00, 8, 1'b0, '0, 8'h00, rx);
    e = exp_rd.pop_front();
    tests_run++;
    if (rx !== e) begin
      tests_failed++;
      $display("FAIL post_reset_read: miso byte=%h, required %h", rx, e);
    end
    spi_end();
    $display("[TB] reset mid-burst recovered, reg9 read %h", rx);
  endtask

  initial begin
    spi_bus.sclk = 1'b0;
    spi_bus.ss_n = 1'b1;
    spi_bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_status_echo();
    test_burst_wrap();
    test_abort();
    test_collision();
    test_reset_mid_burst();
    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_wr.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_commits: %0d expected writes never seen, required 0", exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
